// File: rtl/weight_load_ctrl.sv
// weight_load_ctrl
// Read-side sequencer for the weight-RAM -> neuron-unit demux. On start it
// walks NUM_UNITS*WPU consecutive RAM words (unit-major, slot-minor), and
// delays {valid, unit, slot} by RD_LAT cycles so that write, unit_sel and
// weight_idx line up with the RAM read data.
// Optional feature: define WLC_HOLD_EN to let `hold` stall address issue.
module weight_load_ctrl #(
  parameter  int ADDR_W = 8,
  parameter  int UNIT_W = 2,
  parameter  int WPU    = 16,
  parameter  int RD_LAT = 1,
  localparam int IDX_W  = (WPU > 1) ? $clog2(WPU) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              hold,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_en,
  output logic [UNIT_W-1:0] unit_sel,
  output logic              write,
  output logic [IDX_W-1:0]  weight_idx,
  output logic              busy,
  output logic              done
);

  localparam logic [UNIT_W-1:0] UNIT_LAST = '1;
  localparam logic [UNIT_W-1:0] UNIT_ONE  = UNIT_W'(1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(WPU - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic [UNIT_W-1:0]   unit_r, unit_s;
  logic [IDX_W-1:0]    idx_r, idx_s;
  logic [ADDR_W-1:0]   addr_r, addr_s;
  logic                en_r, en_s;
  logic                busy_r, busy_s;
  logic                done_r, done_s;
  logic                last_s;
  logic                hold_s;
  logic [RD_LAT-1:0]   pipe_v_r, pipe_v_s;
  logic [UNIT_W-1:0]   pipe_unit_r [RD_LAT];
  logic [UNIT_W-1:0]   pipe_unit_s [RD_LAT];
  logic [IDX_W-1:0]    pipe_idx_r  [RD_LAT];
  logic [IDX_W-1:0]    pipe_idx_s  [RD_LAT];

`ifdef WLC_HOLD_EN
  assign hold_s = hold;
`else
  // Stall input is present for pin compatibility but has no effect.
  logic hold_unused_s;
  assign hold_unused_s = hold;
  assign hold_s        = 1'b0;
`endif

  // The word currently presented on the RAM port is the final one of the block.
  assign last_s = (unit_r == UNIT_LAST) && (idx_r == IDX_LAST);

  // Delay pipe shift: stage 0 takes the issue presented this cycle; the unit and
  // slot fields are masked to zero when the stage carries no read.
  always_comb begin
    pipe_v_s[0]    = en_r;
    pipe_unit_s[0] = en_r ? unit_r : '0;
    pipe_idx_s[0]  = en_r ? idx_r  : '0;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_v_s[i]    = pipe_v_r[i-1];
      pipe_unit_s[i] = pipe_unit_r[i-1];
      pipe_idx_s[i]  = pipe_idx_r[i-1];
    end
  end

  // Next-state, issue counters and registered-output values.
  always_comb begin
    state_s = state_r;
    unit_s  = unit_r;
    idx_s   = idx_r;
    addr_s  = addr_r;
    en_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_ISSUE;
          unit_s  = '0;
          idx_s   = '0;
          addr_s  = base_addr;
          en_s    = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (en_r && last_s) begin
          state_s = ST_DRAIN;
        end else begin
          // A held cycle leaves the pending position untouched, so issue
          // resumes at the same address once hold drops.
          en_s = !hold_s;
          if (en_r) begin
            addr_s = addr_r + ADDR_ONE;
            if (idx_r == IDX_LAST) begin
              idx_s  = '0;
              unit_s = unit_r + UNIT_ONE;
            end else begin
              idx_s  = idx_r + IDX_ONE;
            end
          end else begin
            addr_s = addr_r;
          end
        end
      end
      ST_DRAIN: begin
        if (pipe_v_s == '0) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    busy_s = (state_s == ST_ISSUE) || (state_s == ST_DRAIN) || (pipe_v_s != '0);
    done_s = (state_s == ST_DONE);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Issue counters, RAM port, status flags and read-latency delay pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      unit_r   <= '0;
      idx_r    <= '0;
      addr_r   <= '0;
      en_r     <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      pipe_v_r <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_unit_r[i] <= '0;
        pipe_idx_r[i]  <= '0;
      end
    end else begin
      unit_r   <= unit_s;
      idx_r    <= idx_s;
      addr_r   <= addr_s;
      en_r     <= en_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
      pipe_v_r <= pipe_v_s;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_unit_r[i] <= pipe_unit_s[i];
        pipe_idx_r[i]  <= pipe_idx_s[i];
      end
    end
  end

  assign ram_addr   = addr_r;
  assign ram_en     = en_r;
  assign unit_sel   = pipe_unit_r[RD_LAT-1];
  assign write      = pipe_v_r[RD_LAT-1];
  assign weight_idx = pipe_idx_r[RD_LAT-1];
  assign busy       = busy_r;
  assign done       = done_r;

endmodule

// File: tb/tb_weight_load_ctrl.sv
// tb_weight_load_ctrl
// Two instances (RD_LAT=1 and RD_LAT=3, WPU=4) share one stimulus stream.
// Each instance has a reference model that, from the driven inputs alone,
// queues the expected reads, writes and done pulse with their cycle numbers;
// a monitor on the falling edge pops and compares them every cycle.
module tb_weight_load_ctrl;

  localparam int ADDR_W = 8;
  localparam int UNIT_W = 2;
  localparam int WPU    = 4;
  localparam int IDX_W  = 2;
  localparam int NW     = 16;
  localparam int INF    = 32'h3fff_ffff;

  typedef struct {
    int cy;
    int a;
    int u;
    int x;
  } ev_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              hold = 1'b0;
  logic [ADDR_W-1:0] base_addr = 8'h00;
  logic              hold_eff;
  int                cyc = 0;
  int                n_cmp = 0;
  int                n_err = 0;

  logic [ADDR_W-1:0] ram_addr_a   [2];
  logic              ram_en_a     [2];
  logic [UNIT_W-1:0] unit_sel_a   [2];
  logic              write_a      [2];
  logic [IDX_W-1:0]  weight_idx_a [2];
  logic              busy_a       [2];
  logic              done_a       [2];

`ifdef WLC_HOLD_EN
  assign hold_eff = hold;
`else
  assign hold_eff = 1'b0;
`endif

  always #5 clk = ~clk;

  // cyc == n while in the cycle that ends at edge n
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : 3;

    ev_t               iss_q[$];
    ev_t               wr_q[$];
    int                done_q[$];
    logic              m_active = 1'b0;
    int                m_n = 0;
    int                m_free = 0;
    logic [ADDR_W-1:0] m_addr = 8'h00;
    int                busy_from = INF;
    int                busy_to = INF;
    logic              exp_b;

    weight_load_ctrl #(.ADDR_W(ADDR_W), .UNIT_W(UNIT_W), .WPU(WPU), .RD_LAT(L)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .base_addr  (base_addr),
      .hold       (hold),
      .ram_addr   (ram_addr_a[g]),
      .ram_en     (ram_en_a[g]),
      .unit_sel   (unit_sel_a[g]),
      .write      (write_a[g]),
      .weight_idx (weight_idx_a[g]),
      .busy       (busy_a[g]),
      .done       (done_a[g])
    );

    function automatic void push_ev(input int cy, input int a, input int n);
      iss_q.push_back('{cy, a, n / WPU, n % WPU});
      wr_q.push_back('{cy + L, a, n / WPU, n % WPU});
    endfunction

    // reference model: issue n goes out the cycle after the edge that allows it
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        iss_q.delete();
        wr_q.delete();
        done_q.delete();
        m_active  <= 1'b0;
        m_n       <= 0;
        m_free    <= 0;
        busy_from <= INF;
        busy_to   <= INF;
      end else if (!m_active && start && (cyc >= m_free)) begin
        push_ev(cyc + 1, int'(base_addr), 0);
        m_active  <= 1'b1;
        m_n       <= 1;
        m_addr    <= base_addr + 8'd1;
        busy_from <= cyc + 1;
        busy_to   <= INF;
      end else if (m_active) begin
        if (m_n == NW) begin
          m_active <= 1'b0;
          done_q.push_back(cyc + L + 1);
          busy_to  <= cyc + L;
          m_free   <= cyc + L + 2;
        end else if (!hold_eff) begin
          push_ev(cyc + 1, int'(m_addr), m_n);
          m_n    <= m_n + 1;
          m_addr <= m_addr + 8'd1;
        end
      end
    end

    // monitor: compare every output in every cycle against the queued expectations
    always @(negedge clk) begin
      exp_b = (iss_q.size() > 0) && (iss_q[0].cy == cyc);
      check_eq($sformatf("lat%0d ram_en", L), 32'(ram_en_a[g]), 32'(exp_b));
      if (exp_b) begin
        check_eq($sformatf("lat%0d ram_addr", L), 32'(ram_addr_a[g]), iss_q[0].a);
        void'(iss_q.pop_front());
      end
      exp_b = (wr_q.size() > 0) && (wr_q[0].cy == cyc);
      check_eq($sformatf("lat%0d write", L), 32'(write_a[g]), 32'(exp_b));
      if (exp_b) begin
        check_eq($sformatf("lat%0d unit_sel", L), 32'(unit_sel_a[g]), wr_q[0].u);
        check_eq($sformatf("lat%0d weight_idx", L), 32'(weight_idx_a[g]), wr_q[0].x);
        void'(wr_q.pop_front());
      end else begin
        check_eq($sformatf("lat%0d idle_sel_idx", L),
                 32'({unit_sel_a[g], weight_idx_a[g]}), 32'd0);
      end
      exp_b = (done_q.size() > 0) && (done_q[0] == cyc);
      check_eq($sformatf("lat%0d done", L), 32'(done_a[g]), 32'(exp_b));
      if (exp_b) void'(done_q.pop_front());
      check_eq($sformatf("lat%0d busy", L), 32'(busy_a[g]),
               32'((cyc >= busy_from) && (cyc <= busy_to)));
    end
  end

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      check_eq(tag, 32'({ram_addr_a[i], ram_en_a[i], unit_sel_a[i], write_a[i],
                         weight_idx_a[i], busy_a[i], done_a[i]}), 32'd0);
    end
  endtask

  // drive start so that it is sampled at edge e
  task automatic start_at(input int e, input logic [ADDR_W-1:0] b);
    while (cyc < e) @(negedge clk);
    start     = 1'b1;
    base_addr = b;
    @(negedge clk);
    start     = 1'b0;
    base_addr = ~b;
  endtask

  task automatic wait_until(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  initial begin
    int t;
    repeat (2) @(negedge clk);
    check_all_zero("reset_outputs");
    rst_n = 1'b1;

    // basic walk from 0x10
    t = cyc + 2;
    start_at(t, 8'h10);
    wait_until(t + 30);

    // block crossing the top of the address space
    t = cyc + 2;
    start_at(t, 8'hFA);
    wait_until(t + 30);

    // start pulses mid-walk, in the done cycle, and the cycle after done
    t = cyc + 2;
    start_at(t, 8'h40);
    start_at(t + 5, 8'h80);
    start_at(t + 17, 8'h81);
    start_at(t + 18, 8'h82);
    start_at(t + 19, 8'h20);
    wait_until(t + 60);

    // asynchronous reset in the middle of a walk, then a fresh walk
    t = cyc + 2;
    start_at(t, 8'h33);
    wait_until(t + 7);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset_outputs");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    t = cyc + 2;
    start_at(t, 8'h55);
    wait_until(t + 30);

    // hold high in cycles 6..8 of a walk
    t = cyc + 2;
    start_at(t, 8'h00);
    wait_until(t + 6);
    hold = 1'b1;
    wait_until(t + 9);
    hold = 1'b0;
    wait_until(t + 40);

    // random bases with random hold activity
    for (int k = 0; k < 3; k++) begin
      t = cyc + 2;
      start_at(t, 8'($urandom_range(0, 255)));
      for (int j = 0; j < 25; j++) begin
        hold = ($urandom_range(0, 3) == 0);
        @(negedge clk);
      end
      hold = 1'b0;
      wait_until(t + 60);
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
